// File: rtl/lifo_reader.sv
// rtl/lifo_reader.sv - drains up to DEPTH words from a LIFO and re-emits them in push order
module lifo_reader #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       count,
    output logic             read,
    input  logic [WIDTH-1:0] datain,
    input  logic             lifo_val,
    output logic [WIDTH-1:0] dataout,
    output logic             val,
    input  logic             ready,
    output logic             busy,
    output logic             done,
    output logic [3:0]       popped
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NBUF = 1 << AW;
    localparam logic [3:0] DEPTH4 = 4'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_POP, S_WAIT, S_EMIT, S_FIN} state_t;

    state_t           state_q, state_d;
    logic [3:0]       target_q, target_d;
    logic [3:0]       popped_q, popped_d;
    logic [3:0]       k_q, k_d;
    logic [WIDTH-1:0] buf_q [NBUF];
    logic             wr_en;
    logic [3:0]       rd_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            target_q <= '0;
            popped_q <= '0;
            k_q      <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            popped_q <= popped_d;
            k_q      <= k_d;
        end
    end

    // Buffer is cleared on reset so an abandoned transaction leaves nothing behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NBUF; i++) buf_q[i] <= '0;
        end else if (wr_en) begin
            buf_q[popped_q[AW-1:0]] <= datain;
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        popped_d = popped_q;
        k_d      = k_q;
        wr_en    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    target_d = (count > DEPTH4) ? DEPTH4 : count;
                    popped_d = '0;
                    k_d      = '0;
                    state_d  = (count == 4'd0) ? S_FIN : S_POP;
                end
            end
            S_POP: state_d = S_WAIT;
            S_WAIT: begin
                if (lifo_val) begin
                    wr_en    = 1'b1;
                    popped_d = popped_q + 4'd1;
                    state_d  = (popped_q + 4'd1 == target_q) ? S_EMIT : S_POP;
                end else begin
                    state_d = (popped_q == 4'd0) ? S_FIN : S_EMIT;
                end
            end
            S_EMIT: begin
                if (ready) begin
                    if (k_q + 4'd1 == popped_q) state_d = S_FIN;
                    else                        k_d = k_q + 4'd1;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Last-popped word sits at the highest index, so emit from the top down.
    always_comb begin
        rd_full = popped_q - 4'd1 - k_q;
        read    = (state_q == S_POP);
        val     = (state_q == S_EMIT);
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_FIN);
        popped  = popped_q;
        dataout = (state_q == S_EMIT) ? buf_q[rd_full[AW-1:0]] : '0;
    end

endmodule

// File: tb/tb_lifo_reader.sv
// tb/tb_lifo_reader.sv - scoreboard bench for lifo_reader with a behavioural registered LIFO
module tb_lifo_reader;
    localparam int WIDTH = 10;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [3:0]       count = '0;
    logic             read;
    logic [WIDTH-1:0] datain = '0;
    logic             lifo_val = 1'b0;
    logic [WIDTH-1:0] dataout;
    logic             val;
    logic             ready = 1'b1;
    logic             busy;
    logic             done;
    logic [3:0]       popped;

    lifo_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .count(count), .read(read),
        .datain(datain), .lifo_val(lifo_val), .dataout(dataout), .val(val),
        .ready(ready), .busy(busy), .done(done), .popped(popped)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;
    logic [WIDTH-1:0] stack [$];
    logic [WIDTH-1:0] exp_q [$];
    bit               pending = 0;
    bit               ready_mode = 0;
    bit               stall = 0;
    logic [WIDTH-1:0] stall_data = '0;
    int               reads_cnt = 0;
    int               done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Registered LIFO model, ready pattern and output monitor.
    always @(negedge clk) begin
        if (reset) begin
            pending  = 0;
            lifo_val = 1'b0;
            stall    = 0;
        end else begin
            if (pending && stack.size() > 0) begin
                datain   = stack.pop_back();
                lifo_val = 1'b1;
            end else begin
                datain   = '0;
                lifo_val = 1'b0;
            end
            pending = read;
            if (read) reads_cnt++;
            ready = ready_mode ? ~ready : 1'b1;
            if (stall) begin
                check("stall_val", val, 1);
                check("stall_data", dataout, stall_data);
            end
            if (val && ready) begin
                check("word_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("word", dataout, exp_q.pop_front());
            end
            stall      = val && !ready;
            stall_data = dataout;
            if (done) done_cnt++;
        end
    end

    task automatic run(input int c, input bit rmode, input bit mid_start);
        int clamp, n, er, cyc, d0, sz;
        bit mid_on;
        sz    = stack.size();
        clamp = (c > DEPTH) ? DEPTH : c;
        n     = (clamp < sz) ? clamp : sz;
        er    = (clamp == 0) ? 0 : ((sz >= clamp) ? clamp : sz + 1);
        for (int i = sz - n; i < sz; i++) exp_q.push_back(stack[i]);
        reads_cnt  = 0;
        d0         = done_cnt;
        ready_mode = rmode;
        mid_on     = 0;
        @(negedge clk); #1;
        start = 1'b1;
        count = 4'(c);
        @(negedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (done_cnt == d0 && cyc < 300) begin
            if (mid_on) begin
                start  = 1'b0;
                mid_on = 0;
            end else if (mid_start && val) begin
                start     = 1'b1;
                count     = 4'd2;
                mid_start = 0;
                mid_on    = 1;
            end
            @(negedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check("timeout", cyc < 300, 1);
        if (c == 0) check("done_latency0", cyc, 0);
        check("done_pulse", done, 1);
        check("popped", popped, n);
        check("reads", reads_cnt, er);
        check("leftover", exp_q.size(), 0);
        @(negedge clk); #1;
        check("done_one_cycle", done, 0);
        check("busy_idle", busy, 0);
        check("popped_held", popped, n);
        ready_mode = 0;
    endtask

    initial begin
        int d0, cyc;
        #1;
        check("rst_read", read, 0);
        check("rst_val", val, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_popped", popped, 0);
        check("rst_dataout", dataout, 0);
        @(negedge clk); #2;
        reset = 1'b0;

        stack = {10'd1, 10'd2, 10'd4};
        run(3, 0, 0);

        stack = {10'd5, 10'd6};
        run(5, 0, 0);
        check("no_extra_read", stack.size(), 0);

        stack.delete();
        run(4, 0, 0);

        for (int i = 0; i < 10; i++) stack.push_back(10'(100 + i));
        run(12, 0, 0);
        check("stack_left", stack.size(), 2);
        run(0, 0, 0);

        stack.delete();
        for (int i = 0; i < 8; i++) stack.push_back(10'($urandom_range(0, 1023)));
        run(6, 1, 1);

        // Reset landing in the POP cycle must abandon the transaction.
        stack = {10'd7, 10'd8, 10'd9};
        d0 = done_cnt;
        @(negedge clk); #1;
        start = 1'b1;
        count = 4'd3;
        @(negedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!read && cyc < 20) begin
            @(negedge clk); #1;
            cyc++;
        end
        check("reset_reach_pop", read, 1);
        reset = 1'b1;
        #1;
        check("rr_read", read, 0);
        check("rr_val", val, 0);
        check("rr_busy", busy, 0);
        check("rr_done", done, 0);
        check("rr_popped", popped, 0);
        check("rr_dataout", dataout, 0);
        @(negedge clk);
        @(negedge clk); #2;
        reset = 1'b0;
        exp_q.delete();
        repeat (4) @(negedge clk);
        check("no_done_after_reset", done_cnt, d0);
        stack = {10'd300, 10'd301, 10'd302};
        run(2, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
